// File: rtl/guide_pkg.sv
// Shared types and helpers for the minterm scanner: FSM encoding, table width
// and the "any higher minterm" query used to flag the last emitted index.
package guide_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  localparam int N_VARS_DEF = 4;
  localparam int TT_W       = 1 << N_VARS_DEF;
  // Widest table supported (N_VARS = 6); narrower tables are zero-extended.
  localparam int MAX_TT_W   = 64;

  function automatic logic any_set_above(input logic [MAX_TT_W-1:0] table_bits,
                                         input int idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_TT_W; i++) begin
      if (i > idx && table_bits[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/minterm_emitter.sv
// Walks the captured truth table and presents each set index over valid/ready.
// Zero entries are skipped one per cycle; set entries wait for m_ready.
module minterm_emitter
  import guide_pkg::*;
#(
  parameter int N_VARS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     active,
  input  logic [(1<<N_VARS)-1:0]   tt,
  input  logic                     m_ready,
  output logic                     m_valid,
  output logic [N_VARS-1:0]        m_index,
  output logic                     m_last,
  output logic                     finish
);

  localparam int W = 1 << N_VARS;

  // Handshake: a transfer happens on a rising edge where m_valid & m_ready;
  // m_valid never depends on m_ready and holds with m_index/m_last until then.
  logic [N_VARS-1:0] ptr;
  logic              bit_set;
  logic              advance;

  assign bit_set = tt[ptr];
  assign advance = active & (~bit_set | m_ready);
  assign finish  = advance & (ptr == N_VARS'(W - 1));

  always_ff @(posedge clk) begin
    if (reset || !active) ptr <= '0;
    else if (advance)     ptr <= ptr + N_VARS'(1);
  end

  assign m_valid = active & bit_set;
  assign m_index = m_valid ? ptr : '0;
  assign m_last  = m_valid & ~any_set_above(MAX_TT_W'(tt), int'(ptr));

endmodule

// File: rtl/minterm_scanner.sv
// Sweeps every input combination through an external function, captures the
// truth table and minterm count, then streams the set minterm indices out.
module minterm_scanner
  import guide_pkg::*;
#(
  parameter int N_VARS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_VARS-1:0]      probe,
  input  logic                   f_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N_VARS-1:0]      m_index,
  output logic                   m_last,
  output logic [(1<<N_VARS)-1:0] tt,
  output logic [N_VARS:0]        count,
  output logic                   busy,
  output logic                   done
);

  localparam int W = 1 << N_VARS;

  scan_state_e state, state_next;
  logic        emit_finish;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP:   if (probe == N_VARS'(W - 1)) state_next = EMIT;
      EMIT:    if (emit_finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      probe <= '0;
      tt    <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_next == SWEEP) || (state_next == EMIT);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            probe <= '0;
            tt    <= '0;
            count <= '0;
          end
        end
        SWEEP: begin
          tt[probe] <= f_in;
          count     <= count + (N_VARS+1)'(f_in);
          probe     <= probe + N_VARS'(1);
        end
        default: ;
      endcase
    end
  end

  minterm_emitter #(.N_VARS(N_VARS)) u_emitter (
    .clk     (clk),
    .reset   (reset),
    .active  (state == EMIT),
    .tt      (tt),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_index (m_index),
    .m_last  (m_last),
    .finish  (emit_finish)
  );

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner (N_VARS = 4): table of scans plus
// hand-written reset-in-sweep sequence.
module tb_minterm_scanner;
  import guide_pkg::*;

  localparam int NV = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [NV-1:0] probe;
  logic          f_in;
  logic          m_valid;
  logic          m_ready;
  logic [NV-1:0] m_index;
  logic          m_last;
  logic [15:0]   tt;
  logic [NV:0]   count;
  logic          busy;
  logic          done;

  logic [15:0]   func_tt;

  int tests = 0;
  int fails = 0;

  logic [NV-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign f_in = func_tt[probe];

  minterm_scanner #(.N_VARS(NV)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .probe   (probe),
    .f_in    (f_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_index (m_index),
    .m_last  (m_last),
    .tt      (tt),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [15:0] func;
    logic [15:0] exp_tt;
    int          exp_count;
    int          stall_idx;
    int          stall_len;
    bit          mid_start;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_scan(input vec_t v);
    int cyc, done_cyc, pulses, stalls, valid_cycles, transfers, post;
    bit stall_prev;
    logic [NV-1:0] e;
    exp_q.delete();
    for (int i = 0; i < 16; i++) if (v.exp_tt[i]) exp_q.push_back(NV'(i));
    func_tt = v.func;
    m_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cyc = 0; done_cyc = -1; pulses = 0; stalls = 0; valid_cycles = 0;
    transfers = 0; post = 0; stall_prev = 0;
    while (cyc < 200 && post < 4) begin
      if (cyc == 0) check("busy_at_start", 32'(busy), 32'd1);
      if (stall_prev) begin
        check("stall_valid_hold", 32'(m_valid), 32'd1);
        check("stall_index_hold", 32'(m_index), 32'(v.stall_idx));
      end
      start = v.mid_start && (cyc == 5 || cyc == 20);
      if (m_valid && int'(m_index) == v.stall_idx && stalls < v.stall_len) begin
        m_ready = 1'b0;
        stalls++;
        stall_prev = 1;
      end else begin
        m_ready = 1'b1;
        stall_prev = 0;
      end
      if (m_valid) valid_cycles++;
      if (m_valid && m_ready) begin
        transfers++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("m_index", 32'(m_index), 32'(e));
          check("m_last", 32'(m_last), 32'(exp_q.size() == 0));
        end
      end
      if (done) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      if (done_cyc >= 0) post++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b1;
    check("done_cycle", 32'(done_cyc), 32'(v.exp_done_cyc));
    check("done_pulses", 32'(pulses), 32'd1);
    check("tt", 32'(tt), 32'(v.exp_tt));
    check("count", 32'(count), 32'(v.exp_count));
    check("transfers", 32'(transfers), 32'(v.exp_count));
    check("stream_left", 32'(exp_q.size()), 32'd0);
    check("valid_cycles", 32'(valid_cycles), 32'(v.exp_count + stalls));
    check("stalls_seen", 32'(stalls), 32'(v.stall_len));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int waited;
    reset = 1'b1;
    start = 1'b0;
    m_ready = 1'b1;
    func_tt = '0;

    //          func      exp_tt    cnt stall len mid done
    vecs[0] = '{16'h16C5, 16'h16C5, 7,  -1,   0,  0,  32};
    vecs[1] = '{16'h0000, 16'h0000, 0,  -1,   0,  0,  32};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16, -1,   0,  0,  32};
    vecs[3] = '{16'h16C5, 16'h16C5, 7,  2,    3,  0,  35};
    vecs[4] = '{16'h8001, 16'h8001, 2,  -1,   0,  1,  32};
    vecs[5] = '{16'hA5A5, 16'hA5A5, 8,  -1,   0,  0,  32};

    @(negedge clk);
    @(negedge clk);
    check("rst_probe", 32'(probe), 32'd0);
    check("rst_tt", 32'(tt), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i]);
      @(negedge clk);
    end

    // Reset while the sweep is half way through: partial table must vanish.
    func_tt = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (probe != NV'(5) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("reach_probe5", 32'(probe), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_probe", 32'(probe), 32'd0);
    check("midrst_tt", 32'(tt), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    run_scan(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
